// File: rtl/cpu_axi_master.sv
// Single-beat AXI master that turns one CPU read/write request into one AXI transaction.
// Define AXI_MASTER_RESPCHK_EN to enable the sticky err flag on bad response code or ID.
`timescale 1ns/1ps

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module cpu_axi_master #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    input  logic [3:0]                 wstrb,
    output logic [31:0]                rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [`AXI_ID_BITS-1:0]    ARID,
    output logic [31:0]                ARADDR,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
    output logic [1:0]                 ARBURST,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    output logic [`AXI_ID_BITS-1:0]    AWID,
    output logic [31:0]                AWADDR,
    output logic [`AXI_LEN_BITS-1:0]   AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [31:0]                WDATA,
    output logic [`AXI_STRB_BITS-1:0]  WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [`AXI_ID_BITS-1:0]    RID,
    input  logic [31:0]                RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RLAST,
    input  logic                       RVALID,
    output logic                       RREADY,
    input  logic [`AXI_ID_BITS-1:0]    BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
);

    // ST_ prefix keeps the RDATA state name clear of the RDATA port.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP
    } state_t;

    localparam logic [`AXI_SIZE_BITS-1:0] SIZE_WORD = 3'b010;

    state_t                     state_reg, state_next;
    logic [31:0]                addr_reg, addr_next;
    logic [31:0]                wdata_reg, wdata_next;
    logic [`AXI_STRB_BITS-1:0]  wstrb_reg, wstrb_next;
    logic [31:0]                rdata_reg, rdata_next;
    logic                       done_reg, done_next;
    logic                       aw_done_reg, aw_done_next;
    logic                       w_done_reg, w_done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            done_reg    <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            rdata_reg   <= rdata_next;
            done_reg    <= done_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        rdata_next   = rdata_reg;
        done_next    = 1'b0;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            ST_IDLE: begin
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                if (req) begin
                    addr_next  = addr;
                    wdata_next = wdata;
                    wstrb_next = wstrb;
                    state_next = we ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (ARREADY) state_next = ST_RDATA;
            end
            ST_RDATA: begin
                if (RVALID) begin
                    rdata_next = RDATA;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WADDR: begin
                // AW and W complete independently; leave once both have handshaken.
                if (AWREADY) aw_done_next = 1'b1;
                if (WREADY)  w_done_next  = 1'b1;
                if (aw_done_next && w_done_next) state_next = ST_WRESP;
            end
            ST_WRESP: begin
                if (BVALID) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ARID    = MASTER_ID;
    assign AWID    = MASTER_ID;
    assign ARADDR  = addr_reg;
    assign AWADDR  = addr_reg;
    assign ARLEN   = '0;
    assign AWLEN   = '0;
    assign ARSIZE  = SIZE_WORD;
    assign AWSIZE  = SIZE_WORD;
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign ARVALID = (state_reg == ST_RADDR);
    assign AWVALID = (state_reg == ST_WADDR) && !aw_done_reg;
    assign WVALID  = (state_reg == ST_WADDR) && !w_done_reg;
    assign WLAST   = WVALID;
    assign WDATA   = wdata_reg;
    assign WSTRB   = wstrb_reg;
    assign RREADY  = (state_reg == ST_RDATA);
    assign BREADY  = (state_reg == ST_WRESP);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign rdata   = rdata_reg;

`ifdef AXI_MASTER_RESPCHK_EN
    logic err_reg;
    logic resp_bad;
    logic unused_rlast;

    always_comb begin
        resp_bad = 1'b0;
        if (state_reg == ST_RDATA && RVALID)
            resp_bad = (RRESP != 2'b00) || (RID != MASTER_ID);
        else if (state_reg == ST_WRESP && BVALID)
            resp_bad = (BRESP != 2'b00) || (BID != MASTER_ID);
    end

    always_ff @(posedge clk) begin
        if (rst) err_reg <= 1'b0;
        else     err_reg <= err_reg | resp_bad;
    end

    assign err          = err_reg;
    assign unused_rlast = RLAST;
`else
    logic unused_resp;
    assign err         = 1'b0;
    assign unused_resp = ^{RRESP, BRESP, RID, BID, RLAST};
`endif

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: reset, read/write timing, req blocking, mid-flight reset, err.
// Expected err values follow AXI_MASTER_RESPCHK_EN when it is defined for the build.
`timescale 1ns/1ps

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_cpu_axi_master;

    localparam logic [`AXI_ID_BITS-1:0] MID = 4'h5;
`ifdef AXI_MASTER_RESPCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic [`AXI_ID_BITS-1:0]   ARID, AWID, RID, BID;
    logic [31:0]               ARADDR, AWADDR, WDATA, RDATA;
    logic [`AXI_LEN_BITS-1:0]  ARLEN, AWLEN;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE, AWSIZE;
    logic [1:0]                ARBURST, AWBURST, RRESP, BRESP;
    logic [`AXI_STRB_BITS-1:0] WSTRB;
    logic ARVALID, ARREADY, AWVALID, AWREADY, WVALID, WREADY, WLAST;
    logic RLAST, RVALID, RREADY, BVALID, BREADY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_axi_master #(.MASTER_ID(MID)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .busy(busy), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Each tick lands 1 ns after a rising edge: inputs are driven and outputs sampled there.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RID = MID; BID = MID; RDATA = '0; RRESP = 2'b00; RLAST = 1'b1; RVALID = 1'b0;
        BRESP = 2'b00; BVALID = 1'b0;
        tick; tick;

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_valids", {ARVALID, AWVALID, WVALID}, 0);
        check("rst_readys", {RREADY, BREADY}, 0);
        check("const_ar", {ARLEN, ARSIZE, ARBURST}, {8'h00, 3'b010, 2'b01});
        check("const_aw", {AWLEN, AWSIZE, AWBURST, AWID}, {8'h00, 3'b010, 2'b01, MID});
        rst = 1'b0;

        // Reset while in RDATA: the pending read is dropped and RDATA is never captured.
        req = 1'b1; we = 1'b0; addr = 32'h0000_0400; ARREADY = 1'b1;
        tick;                                   // RADDR
        req = 1'b0;
        tick;                                   // RDATA
        check("mid_rready", RREADY, 1);
        rst = 1'b1; RVALID = 1'b1; RDATA = 32'hFFFF_FFFF;
        tick;
        rst = 1'b0; RVALID = 1'b0; ARREADY = 1'b0;
        check("mid_rready_drop", RREADY, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_rdata", rdata, 32'h0);
        tick;
        check("mid_done_after", done, 0);
        check("mid_arvalid_after", ARVALID, 0);
        $display("read  addr=%08h aborted by reset rdata=%08h", 32'h0000_0400, rdata);

        // Zero-wait read: done three cycles after req.
        req = 1'b1; we = 1'b0; addr = 32'h0000_1000; ARREADY = 1'b1;
        check("rd_arvalid_idle", ARVALID, 0);
        tick;                                   // cycle 1: RADDR
        req = 1'b0; addr = 32'hFFFF_FFFF;
        check("rd_arvalid", ARVALID, 1);
        check("rd_araddr", ARADDR, 32'h0000_1000);
        check("rd_arid", ARID, MID);
        check("rd_busy", busy, 1);
        tick;                                   // cycle 2: RDATA
        ARREADY = 1'b0;
        check("rd_arvalid_drop", ARVALID, 0);
        check("rd_rready", RREADY, 1);
        check("rd_done_early", done, 0);
        RVALID = 1'b1; RDATA = 32'hDEAD_BEEF;
        tick;                                   // cycle 3
        RVALID = 1'b0; RDATA = 32'h0;
        check("rd_done", done, 1);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_idle", {busy, RREADY}, 0);
        $display("read  addr=%08h rdata=%08h", 32'h0000_1000, rdata);
        tick;
        check("rd_done_pulse", done, 0);
        check("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Write with AWREADY at cycle 2 and WREADY at cycle 4.
        req = 1'b1; we = 1'b1; addr = 32'h0001_0004; wdata = 32'h1234_5678; wstrb = 4'b0011;
        tick;                                   // cycle 1: WADDR entry
        req = 1'b0; addr = '0; wdata = '0; wstrb = 4'hF;
        check("wr_valids_entry", {AWVALID, WVALID, WLAST}, 3'b111);
        check("wr_awaddr", AWADDR, 32'h0001_0004);
        check("wr_wdata", WDATA, 32'h1234_5678);
        check("wr_wstrb", WSTRB, 4'b0011);
        tick;                                   // cycle 2
        AWREADY = 1'b1;
        check("wr_valids_c2", {AWVALID, WVALID}, 2'b11);
        tick;                                   // cycle 3
        AWREADY = 1'b0;
        check("wr_awvalid_drop", AWVALID, 0);
        check("wr_wvalid_hold", WVALID, 1);
        check("wr_wdata_stable", WDATA, 32'h1234_5678);
        tick;                                   // cycle 4
        WREADY = 1'b1;
        check("wr_wvalid_c4", WVALID, 1);
        check("wr_bready_early", BREADY, 0);
        tick;                                   // cycle 5
        WREADY = 1'b0;
        check("wr_wvalid_drop", {WVALID, WLAST}, 0);
        check("wr_bready", BREADY, 1);
        check("wr_done_early", done, 0);
        BVALID = 1'b1;
        tick;                                   // cycle 6
        BVALID = 1'b0;
        check("wr_done", done, 1);
        check("wr_idle", {busy, BREADY}, 0);
        check("wr_rdata_untouched", rdata, 32'hDEAD_BEEF);
        check("wr_err_okay", err, 0);
        $display("write addr=%08h wdata=%08h wstrb=%04b", 32'h0001_0004, 32'h1234_5678, 4'b0011);
        tick;

        // Second req while busy is ignored; a req held high starts the cycle after done.
        req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
        tick;                                   // RADDR, ARREADY low
        req = 1'b1; we = 1'b1; addr = 32'h0000_0200;
        check("bb_araddr1", ARADDR, 32'h0000_0100);
        tick;
        req = 1'b0;
        check("bb_ignored_aw", AWVALID, 0);
        check("bb_araddr_stable", {ARVALID, ARADDR}, {1'b1, 32'h0000_0100});
        ARREADY = 1'b1;
        tick;                                   // RDATA
        ARREADY = 1'b0;
        check("bb_rready", RREADY, 1);
        RVALID = 1'b1; RDATA = 32'hA5A5_0001;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0300;
        tick;                                   // done cycle, held req accepted here
        RVALID = 1'b0;
        check("bb_done", done, 1);
        check("bb_rdata", rdata, 32'hA5A5_0001);
        check("bb_busy_done", busy, 0);
        $display("read  addr=%08h rdata=%08h", 32'h0000_0100, rdata);
        tick;
        req = 1'b0;
        check("bb_next_start", {busy, ARVALID}, 2'b11);
        check("bb_next_addr", ARADDR, 32'h0000_0300);
        check("bb_done_low", done, 0);
        ARREADY = 1'b1;
        tick;
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0BAD_F00D;
        tick;
        RVALID = 1'b0;
        check("bb_done2", done, 1);
        check("bb_rdata2", rdata, 32'h0BAD_F00D);
        $display("read  addr=%08h rdata=%08h", 32'h0000_0300, rdata);
        tick;

        // Simultaneous AW/W handshake with an error response, then an OKAY read.
        req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'h0000_CAFE; wstrb = 4'hF;
        AWREADY = 1'b1; WREADY = 1'b1;
        tick;
        req = 1'b0;
        check("sim_valids", {AWVALID, WVALID}, 2'b11);
        tick;
        AWREADY = 1'b0; WREADY = 1'b0;
        check("sim_valids_drop", {AWVALID, WVALID}, 2'b00);
        check("sim_bready", BREADY, 1);
        BVALID = 1'b1; BRESP = 2'b10;
        tick;
        BVALID = 1'b0; BRESP = 2'b00;
        check("err_done", done, 1);
        check("err_set", err, ERR_EXP);
        $display("write addr=%08h wdata=%08h bresp=10 err=%0b", 32'h0000_0040, 32'h0000_CAFE, err);
        req = 1'b1; we = 1'b0; addr = 32'h0000_0044; ARREADY = 1'b1;
        tick;
        req = 1'b0;
        tick;
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h1111_2222;
        tick;
        RVALID = 1'b0;
        check("err_rd_done", done, 1);
        check("err_rd_rdata", rdata, 32'h1111_2222);
        check("err_sticky", err, ERR_EXP);
        $display("read  addr=%08h rdata=%08h err=%0b", 32'h0000_0044, rdata, err);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("err_cleared", err, 0);
        check("rdata_cleared", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
